// File: rtl/mem_sram_ctrl_pkg.sv
// Shared constants, state encoding and address helper for the MEM-stage SRAM controller.
package mem_sram_ctrl_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
    localparam int unsigned SRAM_DW           = 16;
    localparam int unsigned PH_CNT_W          = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LOW  = 2'd1;
    localparam state_t HIGH = 2'd2;
    localparam state_t DONE = 2'd3;

    function automatic logic [31:0] byte_to_word(input logic [31:0] addr,
                                                 input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_sram_phase_cnt.sv
// Loadable down-counter; last_o flags the final cycle of an SRAM access phase.
module mem_sram_phase_cnt
    import mem_sram_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = PH_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage word access controller: each 32-bit request becomes two 16-bit async SRAM accesses.
// Optional one-entry read cache enabled by defining MEM_SRAM_CTRL_RDCACHE_EN.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_o,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned WORD_W = SRAM_AW - 1;
    localparam logic [PH_CNT_W-1:0] WAIT_LD = PH_CNT_W'(WAIT_STATES);

    state_t              state_q, state_d;
    logic                op_wr_q;
    logic [WORD_W-1:0]   word_q;
    logic [31:0]         wdata_q;
    logic [SRAM_DW-1:0]  lo_q;
    logic [31:0]         read_data_q;

    logic [31:0]         word_full;
    logic [WORD_W-1:0]   req_word;
    logic                unused_word_bits;
    logic                hit;
    logic                start;
    logic                active;
    logic                ph_load;
    logic                ph_last;

    assign word_full        = byte_to_word(address, BASE_ADDR);
    assign req_word         = word_full[WORD_W-1:0];
    assign unused_word_bits = ^word_full[31:WORD_W];

`ifdef MEM_SRAM_CTRL_RDCACHE_EN
    logic              cvalid_q;
    logic [WORD_W-1:0] ctag_q;
    logic [31:0]       cdata_q;

    assign hit = (state_q == IDLE) && rd_en && !wr_en && cvalid_q && (ctag_q == req_word);

    // NOTE: only the valid bit needs reset; tag and data are meaningless until it is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cvalid_q <= 1'b0;
        end else if (state_q == DONE && !op_wr_q) begin
            cvalid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == DONE) begin
            if (!op_wr_q) begin
                ctag_q  <= word_q;
                cdata_q <= read_data_q;
            end else if (cvalid_q && ctag_q == word_q) begin
                cdata_q <= wdata_q;
            end
        end
    end

    assign read_data = hit ? cdata_q : read_data_q;
`else
    assign hit       = 1'b0;
    assign read_data = read_data_q;
`endif

    assign start  = (state_q == IDLE) && (rd_en || wr_en) && !hit;
    assign active = (state_q == LOW) || (state_q == HIGH);
    assign ready  = ((state_q == IDLE) && !start) || (state_q == DONE);

    assign ph_load = start || ((state_q == LOW) && ph_last);

    mem_sram_phase_cnt #(
        .CNT_W      (PH_CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (ph_load),
        .load_val_i (WAIT_LD),
        .last_o     (ph_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = LOW;
            LOW:     if (ph_last) state_d = HIGH;
            HIGH:    if (ph_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                // A simultaneous rd_en/wr_en resolves to a write.
                op_wr_q <= wr_en;
                word_q  <= req_word;
                wdata_q <= write_data;
            end
            if (state_q == LOW && ph_last && !op_wr_q) begin
                lo_q <= sram_dq_i;
            end
            if (state_q == HIGH && ph_last && !op_wr_q) begin
                read_data_q <= {sram_dq_i, lo_q};
            end
`ifdef MEM_SRAM_CTRL_RDCACHE_EN
            if (hit) begin
                read_data_q <= cdata_q;
            end
`endif
        end
    end

    // Strobes decode straight from state so reset forces them inactive immediately.
    assign sram_ce_n  = !active;
    assign sram_ub_n  = !active;
    assign sram_lb_n  = !active;
    assign sram_we_n  = !(active && op_wr_q);
    assign sram_oe_n  = !(active && !op_wr_q);
    assign sram_dq_oe = active && op_wr_q;
    assign sram_addr  = active ? {word_q, (state_q == HIGH)} : '0;
    assign sram_dq_o  = (active && op_wr_q) ? ((state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                                            : '0;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: word-level reference memory plus async SRAM model.
// Cache-specific expectations follow MEM_SRAM_CTRL_RDCACHE_EN.
module tb_mem_sram_ctrl;

    localparam int unsigned W      = 1;
    localparam logic [31:0] BASE   = 32'h0000_0400;
    localparam int unsigned AW     = 18;
    localparam int unsigned PHASE  = W + 1;
    localparam int unsigned FROZEN = 2 * PHASE + 1;

    logic          clk;
    logic          rst;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o;
    logic [15:0]   sram_dq_i;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ub_n;
    logic          sram_lb_n;

    mem_sram_ctrl #(
        .BASE_ADDR   (BASE),
        .WAIT_STATES (W),
        .SRAM_AW     (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] sram_mem [0:1023];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 16'h0000;

    logic [31:0] ref_words [0:255];
    logic [31:0] exp_rd;
    bit          c_valid;
    int          c_word;

    int tests_run;
    int tests_failed;

    int          access_cyc, we_cyc, oe_cyc, dqoe_cyc;
    logic [17:0] first_addr, last_addr;
    logic [15:0] first_dq, last_dq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        access_cyc = 0; we_cyc = 0; oe_cyc = 0; dqoe_cyc = 0;
        first_addr = '0; last_addr = '0; first_dq = '0; last_dq = '0;
    endtask

    // Called once per negedge: gathers strobe statistics and commits SRAM writes.
    task automatic sram_tick();
        if (!sram_ce_n) begin
            access_cyc++;
            if (access_cyc == 1) begin
                first_addr = sram_addr;
                first_dq   = sram_dq_o;
            end
            last_addr = sram_addr;
            last_dq   = sram_dq_o;
        end
        if (!sram_we_n) we_cyc++;
        if (!sram_oe_n) oe_cyc++;
        if (sram_dq_oe) dqoe_cyc++;
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr[9:0]] = sram_dq_o;
    endtask

    // Entered just after a posedge; leaves just after the posedge that ends the request.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
        int  w;
        bit  is_wr;
        bit  hit;
        bit  done;
        int  frozen;
        w      = int'((addr - BASE) >> 2);
        is_wr  = wr;
        hit    = 1'b0;
`ifdef MEM_SRAM_CTRL_RDCACHE_EN
        hit    = rd && !wr && c_valid && (c_word == w);
`endif
        done   = 1'b0;
        frozen = 0;
        clear_stats();
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            sram_tick();
            if (ready) done = 1'b1;
            else       frozen++;
        end
        check({tag, " completes"}, {31'd0, done}, 32'd1);

        if (is_wr) ref_words[w] = data;
        else       exp_rd = ref_words[w];

        check({tag, " frozen"}, frozen, hit ? 0 : FROZEN);
        check({tag, " accesses"}, access_cyc, hit ? 0 : 2 * PHASE);
        if (is_wr) begin
            check({tag, " we_n cycles"}, we_cyc, 2 * PHASE);
            check({tag, " dq_oe cycles"}, dqoe_cyc, 2 * PHASE);
            check({tag, " oe_n cycles"}, oe_cyc, 0);
            check({tag, " dq low"}, first_dq, data[15:0]);
            check({tag, " dq high"}, last_dq, data[31:16]);
        end else begin
            check({tag, " oe_n cycles"}, oe_cyc, hit ? 0 : 2 * PHASE);
            check({tag, " we_n cycles"}, we_cyc, 0);
            check({tag, " dq_oe cycles"}, dqoe_cyc, 0);
        end
        if (!hit) begin
            check({tag, " addr low"}, first_addr, 2 * w);
            check({tag, " addr high"}, last_addr, 2 * w + 1);
        end
        check({tag, " read_data"}, read_data, exp_rd);

        if (!is_wr) begin
            c_valid = 1'b1;
            c_word  = w;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle ready", ready, 1);
            check("idle ce_n", sram_ce_n, 1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          op;
        int          w;
        logic [31:0] a;

        tests_run    = 0;
        tests_failed = 0;
        exp_rd       = 32'd0;
        c_valid      = 1'b0;
        c_word       = 0;
        for (int i = 0; i < 1024; i++) sram_mem[i] = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            v                    = $urandom;
            ref_words[i]         = v;
            sram_mem[2 * i]      = v[15:0];
            sram_mem[2 * i + 1]  = v[31:16];
        end
        clear_stats();

        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        #2;
        check("reset ready", ready, 1);
        check("reset read_data", read_data, 0);
        check("reset strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("reset dq_oe", sram_dq_oe, 0);
        check("reset sram_addr", sram_addr, 0);
        check("reset dq_o", sram_dq_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        do_req(1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF, "wr408");
        idle(1);
        do_req(1'b1, 1'b0, 32'h0000_0408, 32'h0, "rd408");
        check("rd408 value", read_data, 32'hDEAD_BEEF);
        idle(2);
        check("rd408 held", read_data, 32'hDEAD_BEEF);

        do_req(1'b0, 1'b1, 32'h0000_040C, 32'hCAFE_F00D, "b2b wr");
        do_req(1'b1, 1'b0, 32'h0000_040C, 32'h0, "b2b rd");
        do_req(1'b1, 1'b0, 32'h0000_0408, 32'h0, "b2b rd2");
        idle(1);

        do_req(1'b1, 1'b1, 32'h0000_0410, 32'h0BAD_C0DE, "rdwr");
        check("rdwr keeps read_data", read_data, 32'hDEAD_BEEF);
        idle(1);

        do_req(1'b1, 1'b0, 32'h0000_0408, 32'h0, "rd408 again");
        do_req(1'b0, 1'b1, 32'h0000_0408, 32'h1234_5678, "wr408 new");
        do_req(1'b1, 1'b0, 32'h0000_0408, 32'h0, "rd408 new");
        check("rd408 new value", read_data, 32'h1234_5678);
        idle(1);

        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 3);
            w  = $urandom_range(0, 39);
            a  = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
            case (op)
                0, 1:    do_req(1'b1, 1'b0, a, $urandom, "rand rd");
                2:       do_req(1'b0, 1'b1, a, $urandom, "rand wr");
                default: do_req(1'b1, 1'b1, a, $urandom, "rand rdwr");
            endcase
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        // Reset in the first HIGH cycle of a write to word 50 (never read afterwards).
        clear_stats();
        rd_en      = 1'b0;
        wr_en      = 1'b1;
        address    = BASE + 32'd200;
        write_data = $urandom;
        repeat (1 + PHASE + 1) begin
            @(negedge clk);
            sram_tick();
        end
        check("pre-reset ce_n", sram_ce_n, 0);
        check("pre-reset addr", sram_addr, 101);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        check("mid-reset strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        check("mid-reset dq_oe", sram_dq_oe, 0);
        check("mid-reset dq_o", sram_dq_o, 0);
        check("mid-reset sram_addr", sram_addr, 0);
        check("mid-reset ready", ready, 1);
        check("mid-reset read_data", read_data, 0);
        exp_rd  = 32'd0;
        c_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reset held strobes", sram_ce_n, 1);
        rst = 1'b1;
        idle(1);
        do_req(1'b1, 1'b0, BASE + 32'd12, 32'h0, "post-reset rd");
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- MEM-stage responder for memory requests registered at the EXE/MEM pipeline boundary.
- Accepts word read and write requests: a 32-bit address (ALU result) and 32-bit store data (Rm value).
- Performs each request as two 16-bit accesses to an external asynchronous SRAM.
- Drives ready back to the pipeline; the pipeline uses ~ready as its freeze signal.

Parameters:
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- WAIT_STATES, 1, extra cycles held per 16-bit phase (0..7).
- SRAM_AW, 18, SRAM address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rd_en  input  1  word read request (level, held until ready).
- wr_en  input  1  word write request (level, held until ready).
- address  input  32  byte address.
- write_data  input  32  store data.
- read_data  output  32  load data.
- ready  output  1  1 = no pending request or request completing this cycle.
- sram_addr  output  SRAM_AW  SRAM half-word address.
- sram_dq_o  output  16  write data to SRAM.
- sram_dq_i  input  16  read data from SRAM.
- sram_dq_oe  output  1  pad output enable.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  SRAM strobes, active-low.

Behaviour:
- Address mapping: word = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - sram_addr = {word, 0} in the LOW phase.
  - sram_addr = {word, 1} in the HIGH phase.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - No request: ready = 1.
  - Request present: ready = 0 (combinational, same cycle), latch op, address and write_data, go to LOW.
- LOW: hold for WAIT_STATES+1 cycles (phase counter), then go to HIGH. HIGH: same hold, then go to DONE.
- DONE: ready = 1 for exactly one cycle, then go to IDLE.
  - The pipeline advances at this edge.
  - The next request is sampled in IDLE on the following cycle, so the same request cannot retrigger.
- Latency for WAIT_STATES = W:
  - ready is low for 2(W+1)+1 cycles starting at the cycle the request appears.
  - ready is high in the cycle after that.
  - W = 1 gives 5 frozen cycles.
- Strobes:
  - sram_ce_n, sram_ub_n, sram_lb_n = 0 in LOW/HIGH; 1 otherwise.
  - Write: sram_we_n = 0, sram_dq_oe = 1, sram_dq_o = latched data [15:0] in LOW and [31:16] in HIGH.
  - Read: sram_oe_n = 0, sram_dq_oe = 0.
  - All strobes are 1 and sram_dq_oe = 0 in IDLE/DONE.
- Read capture:
  - sram_dq_i is captured on the last cycle of each phase.
  - read_data = {hi, lo} is valid from DONE and held until the next read reaches DONE.
  - Writes leave read_data unchanged.
- rd_en and wr_en both high: the request is treated as a write.
- Request inputs are ignored outside IDLE; the latched copies are used.
- Reset (asynchronous, any state):
  - State = IDLE; counter = 0; read_data = 0.
  - All strobes = 1; sram_dq_oe = 0; sram_dq_o = 0; sram_addr = 0.
  - ready = 1 if no request is present.

Optional Feature:
- Macro: MEM_SRAM_CTRL_RDCACHE_EN.
- Enabled: one-entry read cache holding a tag (word address), 32-bit data and a valid bit.
  - A read in IDLE that hits keeps ready = 1 combinationally, returns the cached data on read_data that cycle, and stays in IDLE.
  - A miss fills the entry at DONE.
  - A write to the matching word updates the cached data at DONE (write-through).
  - Reset clears valid.
- Disabled: every read performs the full SRAM sequence; no cache storage is synthesized.

Decomposition:
- Shared package holds:
  - state enum: IDLE = 0, LOW = 1, HIGH = 2, DONE = 3;
  - BASE_ADDR default;
  - SRAM data width constant 16.
- One natural sub-module: mem_sram_phase_cnt, a loadable down-counter that flags the last cycle of a phase.

Test Plan:
- Write 0xDEADBEEF to 0x00000408, W = 1 -> sram_addr 4 then 5; dq_o 0xBEEF then 0xDEAD; we_n low 2 cycles per phase; ready low 5 cycles, then high 1 cycle.
- Read 0x00000408 with the SRAM model returning the stored data -> read_data = 0xDEADBEEF in DONE and held afterwards; oe_n low, dq_oe 0.
- Back-to-back write then read with requests held continuously -> each request executes once, ready pulses high once per request, no duplicate access.
- rd_en = wr_en = 1 -> write performed; read_data unchanged.
- Reset asserted during HIGH of a write -> all strobes 1 immediately; state IDLE; a subsequent read completes normally.
- With MEM_SRAM_CTRL_RDCACHE_EN:
  - second read of 0x408 -> ready stays 1 and there is no SRAM access;
  - write 0x12345678 to 0x408, then read -> returns 0x12345678 from cache.
